// File: rtl/i2c_tx.sv
// I2C slave-transmitter bit controller.
// After the address phase selects a slave read, bytes are pulled from the
// register/FIFO side and shifted out MSB first on SDA. Each SDA change waits
// HOLD_CYCLES clocks after SCL falls. SDA is then released for the master's
// ACK/NACK. STOP, repeated START or a dropped enable return the block to IDLE.
module i2c_tx #(
  parameter int HOLD_CYCLES = 4,
  parameter int HOLD_W      = 8
) (
  input  logic       clk,
  input  logic       rst_an,
  input  logic       enable,
  input  logic       go,
  input  logic       scl_rise,
  input  logic       scl_fall,
  input  logic       start_det,
  input  logic       stop_det,
  input  logic       sda_in,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       sda_drive_n,
  output logic       active,
  output logic       ack_rcvd,
  output logic       nack_rcvd,
  output logic       underrun
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

  typedef enum logic [2:0] {
    IDLE, LOAD, DATALO, DATAHI, ACKLO, ACKHI, WAIT_STOP
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        shift, shift_nxt;
  logic [3:0]        bitcnt, bitcnt_nxt;
  logic              sda_nxt;
  logic              ack_q, ack_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_over;
  logic              abort;

  assign hold_over = (hold_cnt == HOLD_MAX);
  assign abort     = stop_det | start_det | ~enable;
  assign active    = (state != IDLE);

  // Hold timer: restarts on every SCL fall (and on go) and saturates at HOLD_MAX.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an)                 hold_cnt <= HOLD_MAX;
    else if (scl_fall | go)      hold_cnt <= '0;
    else if (!hold_over)         hold_cnt <= hold_cnt + 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) state <= IDLE;
    else         state <= state_nxt;
  end

  // Datapath registers. Reset releases SDA immediately, without waiting for clk.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      shift       <= 8'hFF;
      bitcnt      <= '0;
      sda_drive_n <= 1'b1;
      ack_q       <= 1'b0;
    end else begin
      shift       <= shift_nxt;
      bitcnt      <= bitcnt_nxt;
      sda_drive_n <= sda_nxt;
      ack_q       <= ack_nxt;
    end
  end

  // Next state, datapath updates and pulse outputs. An abort overrides all
  // normal transitions and masks every pulse in that cycle.
  always_comb begin
    state_nxt  = state;
    shift_nxt  = shift;
    bitcnt_nxt = bitcnt;
    sda_nxt    = sda_drive_n;
    ack_nxt    = ack_q;
    tx_ready   = 1'b0;
    underrun   = 1'b0;
    ack_rcvd   = 1'b0;
    nack_rcvd  = 1'b0;
    if (abort) begin
      state_nxt  = IDLE;
      sda_nxt    = 1'b1;
      bitcnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          sda_nxt = 1'b1;
          if (go) state_nxt = LOAD;
        end
        LOAD: begin
          tx_ready = 1'b1;
          if (tx_valid) shift_nxt = tx_data;
          else begin
            shift_nxt = 8'hFF;
            underrun  = 1'b1;
          end
          bitcnt_nxt = '0;
          state_nxt  = DATALO;
        end
        DATALO: begin
          if (hold_over) sda_nxt = shift[7];
          if (scl_rise)  state_nxt = DATAHI;
        end
        DATAHI: begin
          if (scl_fall) begin
            shift_nxt  = {shift[6:0], 1'b1};
            bitcnt_nxt = bitcnt + 4'd1;
            state_nxt  = (bitcnt == 4'd7) ? ACKLO : DATALO;
          end
        end
        ACKLO: begin
          if (hold_over) sda_nxt = 1'b1;
          if (scl_rise) begin
            ack_nxt   = ~sda_in;
            state_nxt = ACKHI;
          end
        end
        ACKHI: begin
          if (scl_fall) begin
            if (ack_q) begin
              ack_rcvd  = 1'b1;
              state_nxt = LOAD;
            end else begin
              nack_rcvd = 1'b1;
              state_nxt = WAIT_STOP;
            end
          end
        end
        WAIT_STOP: sda_nxt = 1'b1;
        default:   state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_tx.sv
// Scoreboard bench for i2c_tx: stimulus pushes expected output events
// (tx_ready, underrun, ack/nack pulses, SDA transitions, each with its cycle)
// and a negedge monitor pops and compares them as the DUT produces them.
module tb_i2c_tx;
  localparam int HOLD = 4;

  logic       clk = 0, rst_an = 0, enable = 0, go = 0;
  logic       scl_rise = 0, scl_fall = 0, start_det = 0, stop_det = 0;
  logic       sda_in = 1, tx_valid = 0;
  logic [7:0] tx_data = '0;
  logic       tx_ready, sda_drive_n, active, ack_rcvd, nack_rcvd, underrun;

  i2c_tx #(.HOLD_CYCLES(HOLD), .HOLD_W(8)) dut (
    .clk(clk), .rst_an(rst_an), .enable(enable), .go(go),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start_det(start_det),
    .stop_det(stop_det), .sda_in(sda_in), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .sda_drive_n(sda_drive_n),
    .active(active), .ack_rcvd(ack_rcvd), .nack_rcvd(nack_rcvd),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // event kinds: 0 tx_ready, 1 underrun, 2 ack_rcvd, 3 nack_rcvd, 4 SDA change
  typedef struct {int kind; logic val; int t;} ev_t;
  ev_t  exp_q[$];
  int   n_chk = 0, n_pass = 0;
  logic sda_model = 1'b1;
  logic mon_prev  = 1'b1;

  task automatic expect_ev(input int k, input logic v, input int t);
    ev_t e;
    e.kind = k; e.val = v; e.t = t;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic observe(input int k, input logic v);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0)
      $display("FAIL unexpected_event: got kind=%0d val=%0b cyc=%0d, expected none", k, v, cyc);
    else begin
      e = exp_q.pop_front();
      if (e.kind == k && e.val === v && e.t == cyc) n_pass++;
      else $display("FAIL event: got kind=%0d val=%0b cyc=%0d, expected kind=%0d val=%0b cyc=%0d",
                    k, v, cyc, e.kind, e.val, e.t);
    end
  endtask

  // Monitor: report DUT output events in a fixed per-cycle order.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_an) mon_prev = sda_drive_n;
      else begin
        if (tx_ready)  observe(0, 1'b1);
        if (underrun)  observe(1, 1'b1);
        if (ack_rcvd)  observe(2, 1'b1);
        if (nack_rcvd) observe(3, 1'b1);
        if (sda_drive_n !== mon_prev) begin
          observe(4, sda_drive_n);
          mon_prev = sda_drive_n;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One SCL period: 7 low cycles, rise, 4 high cycles, fall. Optionally expects
  // a pulse (kind ev_kind) in the cycle the fall is presented.
  task automatic scl_clock(input int ev_kind, output int f);
    repeat (7) tick();
    scl_rise = 1; tick(); scl_rise = 0;
    repeat (4) tick();
    if (ev_kind >= 0) expect_ev(ev_kind, 1'b1, cyc);
    scl_fall = 1; tick(); scl_fall = 0;
    f = cyc;
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, input int t0, output int f);
    int tt;
    tt = t0 + HOLD + 1;
    f  = t0;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (b[i] !== sda_model) begin
        expect_ev(4, b[i], tt);
        sda_model = b[i];
      end
      scl_clock(-1, f);
      tt = f + HOLD + 1;
    end
  endtask

  task automatic byte_xfer(input logic [7:0] d, input bit v, input bit mack,
                           input logic [7:0] next_d, input int t_load, output int f);
    logic [7:0] b;
    b = v ? d : 8'hFF;
    expect_ev(0, 1'b1, t_load);
    if (!v) expect_ev(1, 1'b1, t_load);
    send_bits(b, 8, t_load, f);
    tx_data = next_d;
    if (sda_model !== 1'b1) begin
      expect_ev(4, 1'b1, f + HOLD + 1);
      sda_model = 1'b1;
    end
    sda_in = mack ? 1'b0 : 1'b1;
    scl_clock(mack ? 2 : 3, f);
    sda_in = 1'b1;
  endtask

  task automatic start_read(output int e);
    go = 1; tick(); go = 0;
    e = cyc;
  endtask

  task automatic pulse_stop();
    stop_det = 1; tick(); stop_det = 0;
  endtask

  int e, f, f2;

  initial begin
    // reset values
    repeat (3) tick();
    chk("rst_sda", sda_drive_n, 1);
    chk("rst_active", active, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_pulses", {ack_rcvd, nack_rcvd, underrun}, 0);
    rst_an = 1; enable = 1;
    repeat (2) tick();
    chk("idle_active", active, 0);

    // A5 with master ACK, then 3C with master NACK
    tx_valid = 1; tx_data = 8'hA5;
    start_read(e);
    chk("go_active", active, 1);
    byte_xfer(8'hA5, 1, 1, 8'h3C, e, f);
    byte_xfer(8'h3C, 1, 0, 8'h00, f, f2);
    repeat (3) tick();
    chk("waitstop_active", active, 1);
    chk("waitstop_sda", sda_drive_n, 1);
    pulse_stop();
    chk("stop_idle", active, 0);

    // underrun: tx_data ignored, eight 1 bits
    tx_valid = 0; tx_data = 8'h00;
    start_read(e);
    byte_xfer(8'h00, 0, 0, 8'h00, e, f);
    pulse_stop();
    chk("underrun_idle", active, 0);

    // go together with stop: stop wins
    tx_valid = 1;
    go = 1; stop_det = 1; tick(); go = 0; stop_det = 0;
    chk("go_stop_idle", active, 0);
    repeat (3) tick();

    // stop after bit 3 of 00 while SDA is low
    tx_data = 8'h00;
    start_read(e);
    expect_ev(0, 1'b1, e);
    send_bits(8'h00, 3, e, f);
    repeat (3) tick();
    chk("mid_sda_low", sda_drive_n, 0);
    expect_ev(4, 1'b1, cyc + 1); sda_model = 1'b1;
    pulse_stop();
    chk("abort_sda", sda_drive_n, 1);
    chk("abort_idle", active, 0);
    repeat (3) tick();
    // next transfer restarts at MSB
    tx_data = 8'h7F;
    start_read(e);
    byte_xfer(8'h7F, 1, 0, 8'h00, e, f);
    pulse_stop();

    // repeated START while in DATAHI
    tx_data = 8'h00;
    start_read(e);
    expect_ev(0, 1'b1, e);
    expect_ev(4, 1'b0, e + HOLD + 1); sda_model = 1'b0;
    repeat (7) tick();
    scl_rise = 1; tick(); scl_rise = 0;
    tick();
    expect_ev(4, 1'b1, cyc + 1); sda_model = 1'b1;
    start_det = 1; tick(); start_det = 0;
    chk("rstart_idle", active, 0);
    chk("rstart_sda", sda_drive_n, 1);
    repeat (3) tick();

    // enable dropped in ACKLO while SDA still holds the last (0) bit
    tx_data = 8'hFE;
    start_read(e);
    expect_ev(0, 1'b1, e);
    send_bits(8'hFE, 8, e, f);
    chk("acklo_sda_low", sda_drive_n, 0);
    expect_ev(4, 1'b1, cyc + 1); sda_model = 1'b1;
    enable = 0; tick(); enable = 1;
    chk("disable_idle", active, 0);
    chk("disable_sda", sda_drive_n, 1);
    repeat (3) tick();

    // asynchronous reset while SDA is pulled low
    tx_data = 8'h00;
    start_read(e);
    expect_ev(0, 1'b1, e);
    expect_ev(4, 1'b0, e + HOLD + 1); sda_model = 1'b0;
    repeat (HOLD + 2) tick();
    chk("pre_rst_sda", sda_drive_n, 0);
    #2; rst_an = 0; #1;
    chk("async_rst_sda", sda_drive_n, 1);
    chk("async_rst_active", active, 0);
    chk("async_rst_ready", tx_ready, 0);
    sda_model = 1'b1;
    repeat (2) tick();
    rst_an = 1;
    repeat (2) tick();

    // recovery after reset
    tx_data = 8'h81;
    start_read(e);
    byte_xfer(8'h81, 1, 0, 8'h00, e, f);
    pulse_stop();
    chk("final_idle", active, 0);

    repeat (10) tick();
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL pending_events: got %0d outstanding expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
